// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the unified memory port arbiter: FSM state, owner encoding
// and default widths.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } arb_state_e;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_e;

    localparam int DEF_AW          = 32;
    localparam int DEF_DW          = 32;
    localparam int DEF_MAX_D_BURST = 4;
    // Wide enough for MAX_D_BURST up to 15.
    localparam int STARVE_W        = 4;

endpackage

// File: rtl/mem_arb_pick.sv
// Fixed D-over-I priority pick with a starvation counter that forces an I
// grant after MAX_D_BURST consecutive D grants while I is waiting.
module mem_arb_pick
    import mem_port_arbiter_pkg::*;
#(
    parameter int MAX_D_BURST = DEF_MAX_D_BURST
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic i_req,
    input  logic d_req,
    output logic grant_i,
    output logic grant_d
);

    logic [STARVE_W-1:0] starve_q;
    logic [STARVE_W-1:0] starve_d;
    logic                starve_full;

    assign starve_full = (starve_q == STARVE_W'(MAX_D_BURST));

    always_comb begin
        grant_d = en & d_req & ~(i_req & starve_full);
        grant_i = en & i_req & ~grant_d;
    end

    // Counts only D grants that actually made I wait; saturates at the limit.
    always_comb begin
        starve_d = starve_q;
        if (grant_i) begin
            starve_d = '0;
        end else if (grant_d && i_req && !starve_full) begin
            starve_d = starve_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch (I) and load/store (D):
// one transaction in flight, responses routed to the owner, stale fetches dropped.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int AW          = DEF_AW,
    parameter int DW          = DEF_DW,
    parameter int MAX_D_BURST = DEF_MAX_D_BURST
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            i_req,
    input  logic [AW-1:0]   i_addr,
    output logic            i_ready,
    output logic            i_rvalid,
    output logic [DW-1:0]   i_rdata,
    input  logic            flush,
    input  logic            d_req,
    input  logic            d_we,
    input  logic [AW-1:0]   d_addr,
    input  logic [DW-1:0]   d_wdata,
    input  logic [DW/8-1:0] d_wstrb,
    output logic            d_ready,
    output logic            d_rvalid,
    output logic [DW-1:0]   d_rdata,
    output logic            m_req,
    output logic            m_we,
    output logic [AW-1:0]   m_addr,
    output logic [DW-1:0]   m_wdata,
    output logic [DW/8-1:0] m_wstrb,
    input  logic            m_ready,
    input  logic            m_rvalid,
    input  logic [DW-1:0]   m_rdata,
    output logic            proto_err
);

    localparam int SW = DW / 8;

    arb_state_e      state_q, state_d;
    owner_e          owner_q, owner_d;
    logic            drop_q, drop_d;
    logic            perr_q, perr_d;
    logic            m_req_q, m_req_d;
    logic            m_we_q, m_we_d;
    logic [AW-1:0]   m_addr_q, m_addr_d;
    logic [DW-1:0]   m_wdata_q, m_wdata_d;
    logic [SW-1:0]   m_wstrb_q, m_wstrb_d;

    logic arb_en;
    logic grant_i;
    logic grant_d;
    logic rsp;

    // Arbitration is gated by reset so no ready pulse leaks while held in reset.
    assign arb_en = (state_q == ST_IDLE) & reset;
    assign rsp    = (state_q == ST_WAIT) & m_rvalid;

    mem_arb_pick #(
        .MAX_D_BURST (MAX_D_BURST)
    ) u_pick (
        .clk     (clk),
        .reset   (reset),
        .en      (arb_en),
        .i_req   (i_req),
        .d_req   (d_req),
        .grant_i (grant_i),
        .grant_d (grant_d)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (grant_i || grant_d) state_d = ST_ISSUE;
            ST_ISSUE: if (m_ready) state_d = m_we_q ? ST_IDLE : ST_WAIT;
            ST_WAIT:  if (m_rvalid) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        i_ready  = grant_i;
        d_ready  = grant_d;
        // A flush in the response cycle itself also kills the fetch data.
        i_rvalid = rsp & (owner_q == OWN_I) & ~drop_q & ~flush;
        d_rvalid = rsp & (owner_q == OWN_D);
        i_rdata  = ((state_q == ST_WAIT) && (owner_q == OWN_I)) ? m_rdata : '0;
        d_rdata  = ((state_q == ST_WAIT) && (owner_q == OWN_D)) ? m_rdata : '0;
    end

    always_comb begin
        m_req_d   = m_req_q;
        m_we_d    = m_we_q;
        m_addr_d  = m_addr_q;
        m_wdata_d = m_wdata_q;
        m_wstrb_d = m_wstrb_q;
        owner_d   = owner_q;
        if (grant_i) begin
            m_req_d   = 1'b1;
            m_we_d    = 1'b0;
            m_addr_d  = i_addr;
            m_wdata_d = '0;
            m_wstrb_d = '0;
            owner_d   = OWN_I;
        end else if (grant_d) begin
            m_req_d   = 1'b1;
            m_we_d    = d_we;
            m_addr_d  = d_addr;
            m_wdata_d = d_wdata;
            m_wstrb_d = d_wstrb;
            owner_d   = OWN_D;
        end else if ((state_q == ST_ISSUE) && m_ready) begin
            m_req_d   = 1'b0;
        end

        drop_d = drop_q;
        if (flush && (owner_q == OWN_I) &&
            ((state_q == ST_ISSUE) || (state_q == ST_WAIT))) begin
            drop_d = 1'b1;
        end
        if (rsp) begin
            drop_d = 1'b0;
        end

        perr_d = perr_q | (m_rvalid & (state_q != ST_WAIT));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            owner_q   <= OWN_I;
            drop_q    <= 1'b0;
            perr_q    <= 1'b0;
            m_req_q   <= 1'b0;
            m_we_q    <= 1'b0;
            m_addr_q  <= '0;
            m_wdata_q <= '0;
            m_wstrb_q <= '0;
        end else begin
            owner_q   <= owner_d;
            drop_q    <= drop_d;
            perr_q    <= perr_d;
            m_req_q   <= m_req_d;
            m_we_q    <= m_we_d;
            m_addr_q  <= m_addr_d;
            m_wdata_q <= m_wdata_d;
            m_wstrb_q <= m_wstrb_d;
        end
    end

    assign m_req     = m_req_q;
    assign m_we      = m_we_q;
    assign m_addr    = m_addr_q;
    assign m_wdata   = m_wdata_q;
    assign m_wstrb   = m_wstrb_q;
    assign proto_err = perr_q;

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single unified memory port between the instruction-fetch requester (I) and the execute-stage load/store requester (D).
- Arbitrates, issues one transaction at a time to memory and routes read responses back to the owner.
- Drops stale fetch responses after a branch flush; its handshakes drive the fetch and load stall conditions of the pipeline.

Parameters:
- AW, 32, address width
- DW, 32, data width (byte strobes = DW/8)
- MAX_D_BURST, 4, max consecutive D grants while I is waiting before I is forced a grant (1..15)

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous, active-low reset
- i_req  input  1  fetch request; held stable until i_ready
- i_addr  input  AW  fetch address
- i_ready  output  1  one-cycle pulse: fetch request accepted
- i_rvalid  output  1  fetch read data valid
- i_rdata  output  DW  fetch read data
- flush  input  1  branch redirect; kill any outstanding fetch response
- d_req  input  1  load/store request; held stable until d_ready
- d_we  input  1  1 = store, 0 = load
- d_addr  input  AW  data address
- d_wdata  input  DW  store data
- d_wstrb  input  DW/8  store byte enables
- d_ready  output  1  one-cycle pulse: data request accepted
- d_rvalid  output  1  load data valid
- d_rdata  output  DW  load data
- m_req  output  1  memory request, held until m_ready
- m_we  output  1  memory write
- m_addr  output  AW  memory address
- m_wdata  output  DW  memory write data
- m_wstrb  output  DW/8  memory byte enables
- m_ready  input  1  memory accepts request this cycle
- m_rvalid  input  1  memory read response valid
- m_rdata  input  DW  memory read data
- proto_err  output  1  sticky: m_rvalid received outside WAIT

Behaviour:
- Reset (async, active-low), mid-operation included:
  - State IDLE; owner=I; drop=0; starve=0.
  - All outputs 0: m_* registers, i_ready, d_ready, proto_err.
  - In-flight memory response after reset is ignored and sets proto_err.
- FSM states IDLE, ISSUE, WAIT.
- IDLE arbitration:
  - D only -> grant D. I only -> grant I.
  - Both requesting: grant D unless starve==MAX_D_BURST, then grant I.
  - On grant: pulse that requester's ready in the same cycle; latch the request into m_* registers; set owner; go ISSUE.
  - m_req rises the cycle after the ready pulse. Minimum request-to-m_req latency is 1 cycle.
- Starvation counter: +1 (saturating) on a D grant while i_req=1; cleared on any I grant; unchanged otherwise.
- ISSUE: hold m_req and all m_* stable until m_ready=1. Then:
  - Write (m_we=1): m_req=0, go IDLE. No response is generated.
  - Read: m_req=0, go WAIT.
- WAIT: on m_rvalid, go IDLE.
  - Owner D: d_rvalid=1, d_rdata=m_rdata (combinational pass-through).
  - Owner I: i_rvalid=!drop, i_rdata=m_rdata.
  - drop clears in the same cycle.
- Back-to-back transactions: a new grant is possible in the cycle after the return to IDLE. Full read turnaround is at least 3 cycles.
- flush:
  - Owner=I and state ISSUE/WAIT: set drop. The transaction still completes on memory; the response is suppressed.
  - flush concurrent with the m_rvalid response: that response is suppressed.
  - flush in IDLE: no effect. The fetch unit presents a new address.
  - flush never affects a D transaction.
- i_rvalid/d_rvalid are never 1 outside WAIT, and never 1 simultaneously.
- i_ready and d_ready are never 1 simultaneously.
- m_rvalid in IDLE/ISSUE: ignored, proto_err <= 1 (cleared only by reset).
- m_ready outside ISSUE: ignored.

Decomposition:
- Shared package/header:
  - FSM state encoding (IDLE=2'd0, ISSUE=2'd1, WAIT=2'd2)
  - owner encoding (OWN_I=1'b0, OWN_D=1'b1)
  - default widths
- One sub-module: mem_arb_pick. Combinational priority/starvation pick plus the saturating starve counter register; outputs grant_i / grant_d.

Test Plan:
- Reset with i_req=1, then release: cycle 0 i_ready=1; cycle 1 m_req=1, m_addr=i_addr=0x100; m_ready at 1; m_rvalid at 3 with 0xDEADBEEF -> i_rvalid=1, i_rdata=0xDEADBEEF; d_rvalid=0.
- Store d_we=1, d_addr=0x2003, d_wstrb=4'b1000, d_wdata=0x11223344 -> m_we=1, m_wstrb=1000 held until m_ready; FSM back in IDLE the next cycle; d_rvalid never asserted.
- i_req and d_req held high continuously, MAX_D_BURST=4, loads answered in 1 cycle -> grant sequence D,D,D,D,I,D,D,D,D,I.
- Fetch issued at 0x40, flush pulsed while in WAIT, then m_rvalid -> i_rvalid stays 0; next fetch at 0x80 returns data normally with i_rvalid=1.
- m_rvalid injected while in IDLE -> proto_err=1 and stays 1; no i_rvalid/d_rvalid; reset clears it.
- reset asserted during WAIT with owner D -> all outputs 0 immediately; after release, the late m_rvalid sets proto_err; a new d_req is granted normally.
